cache_fill_fsm: RTL and testbench
=================================

Name: cache_fill_fsm

Overview:
- Miss handler that sits directly upstream of the CPU's fetch and memory stages.
- On a cache miss, it fetches the whole block from the multi-cycle main memory. Each returned word is written into the cache data array, and the tag array is written with the last word.
- fsm_busy stalls the pipeline (PC hold and pipeline-register enable) for the whole fill.
- The instruction cache and the data cache each get one instance; a small arbiter (outside this block) shares the memory port between them.

Parameters:
- ADDR_WIDTH, 16, byte-address width.
- BLOCK_WORDS, 8, 16-bit words per cache block; power of 2, ≥2.
- Block offset bits: OFF = log2(BLOCK_WORDS)+1 (4 at default).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- miss_detected  in  1  cache lookup missed this cycle; sampled only in IDLE.
- miss_address  in  ADDR_WIDTH  byte address of the missing access.
- fsm_busy  out  1  fill in progress; pipeline must stall.
- mem_read_req  out  1  read request to main memory this cycle.
- memory_address  out  ADDR_WIDTH  byte address of the current request.
- memory_data_valid  in  1  memory returns one word this cycle, in request order.
- memory_data  in  16  returned word.
- write_data_array  out  1  write fill_data into the data array this cycle.
- write_tag_array  out  1  write tag/valid for the block this cycle.
- fill_word  out  log2(BLOCK_WORDS)  word index within the block for the data-array write.
- fill_data  out  16  data for the data-array write; equals memory_data.

Behaviour:
- States: IDLE, FILL. The state, base (ADDR_WIDTH), issue_cnt and recv_cnt (log2(BLOCK_WORDS)+1 bits each) are registered.
- Reset (rst_n=0 at a clock edge):
  - state←IDLE; base, issue_cnt, recv_cnt ←0.
  - Every output reads 0 in the cycle after reset: fsm_busy, mem_read_req, write_data_array, write_tag_array, memory_address, fill_word.
- IDLE:
  - fsm_busy = miss_detected (combinational), so the stall starts in the miss cycle itself.
  - On miss_detected: base←{miss_address[ADDR_WIDTH-1:OFF], OFF'b0}; issue_cnt←0; recv_cnt←0; state←FILL.
  - No request is issued in the miss cycle.
- FILL:
  - fsm_busy=1.
  - mem_read_req = (issue_cnt < BLOCK_WORDS).
  - memory_address = base + 2*issue_cnt when requesting, otherwise base.
  - issue_cnt increments on every requesting cycle. Exactly BLOCK_WORDS requests are issued on consecutive cycles, never more.
  - On memory_data_valid: write_data_array=1, fill_word = recv_cnt[log2(BLOCK_WORDS)-1:0], fill_data=memory_data, recv_cnt increments.
  - On the valid with recv_cnt == BLOCK_WORDS-1: write_tag_array=1 in the same cycle; state←IDLE.
- Latency: with memory read latency L and back-to-back returns, the fill lasts 1 + L + BLOCK_WORDS cycles from the miss cycle. fsm_busy drops on the cycle after the tag write.
- Combinational outputs: write_data_array, write_tag_array, fill_word, fill_data and fsm_busy depend combinationally on state/counters and on memory_data_valid or miss_detected. There are no added pipeline registers.
- Boundaries:
  - memory_data_valid in IDLE: ignored, no writes.
  - miss_detected in FILL: ignored; base is held. The cache re-evaluates after the stall and re-asserts the miss if still needed.
  - miss_detected in the cycle the FSM returns to IDLE, i.e. the cycle after the tag write: accepted as a new miss.
  - Gaps between valids are tolerated; recv_cnt advances only on valid.
  - Returns can begin while requests are still being issued; issue and receive proceed independently in the same cycle.
  - Address arithmetic wraps modulo 2^ADDR_WIDTH. A block at 0xFFF0 requests 0xFFF0..0xFFFE with no carry out.
  - Odd miss_address: the low bits are discarded by the base alignment.
  - Reset mid-fill: immediate return to IDLE with counters cleared. Valids still in flight from memory arrive in IDLE and are ignored. The tag is never written for an aborted fill.

Test Plan:
- Reset hold 3 cycles, then release, with memory_data_valid=1 and memory_data=0xBEEF driven → all outputs 0; no write_data_array pulse; state stays IDLE.
- miss_detected=1 with miss_address=0x1236, memory latency 4, returns 0xA000+i → fsm_busy high from the miss cycle for 13 cycles.
  - Requests issue to 0x1230, 0x1232, …, 0x123E on 8 consecutive cycles.
  - write_data_array pulses with fill_word 0..7 and data 0xA000..0xA007.
  - write_tag_array coincides with word 7; fsm_busy low the following cycle.
- Same miss with valid gaps (pattern 1,0,0,1,…) → exactly 8 data writes, in order; tag written only with the 8th; no extra requests.
- Second miss_detected (miss_address=0x4000) asserted mid-fill → ignored; memory_address never shows 0x4xxx during the fill. A miss asserted the cycle after the tag write → new fill from base 0x4000.
- miss_address=0xFFF8 → requests 0xFFF0..0xFFFE; no wrap to 0x0000 within the block.
- rst_n low for one cycle after 3 words are received → IDLE next cycle with all outputs 0. Remaining in-flight valids cause no writes and write_tag_array never pulses. A new miss afterwards completes a normal fill.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// Block-fill miss handler: on a cache miss, streams one aligned block from main memory
// into the data array, then writes the tag array together with the last word.
module cache_fill_fsm #(
    parameter int ADDR_WIDTH  = 16,
    parameter int BLOCK_WORDS = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           miss_detected,
    input  logic [ADDR_WIDTH-1:0]          miss_address,
    output logic                           fsm_busy,
    output logic                           mem_read_req,
    output logic [ADDR_WIDTH-1:0]          memory_address,
    input  logic                           memory_data_valid,
    input  logic [15:0]                    memory_data,
    output logic                           write_data_array,
    output logic                           write_tag_array,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
    output logic [15:0]                    fill_data
);

    localparam int WW  = $clog2(BLOCK_WORDS);
    localparam int CW  = WW + 1;
    localparam int OFF = WW + 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << OFF) - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_FILL = 1'b1;

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] base;
    logic [CW-1:0]         issue_cnt;
    logic [CW-1:0]         recv_cnt;

    logic in_fill;
    logic issuing;
    logic recv;
    logic last;

    always_comb begin
        in_fill          = (state == S_FILL);
        issuing          = in_fill && (issue_cnt < CW'(BLOCK_WORDS));
        recv             = in_fill && memory_data_valid;
        last             = recv && (recv_cnt == CW'(BLOCK_WORDS - 1));

        // Stall starts combinationally in the miss cycle itself.
        fsm_busy         = in_fill || miss_detected;
        mem_read_req     = issuing;
        memory_address   = issuing ? base + ADDR_WIDTH'({issue_cnt, 1'b0}) : base;
        write_data_array = recv;
        write_tag_array  = last;
        fill_word        = recv ? recv_cnt[WW-1:0] : '0;
        fill_data        = memory_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            base      <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (miss_detected) begin
                        base      <= miss_address & ~ALIGN_MASK;
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
                        state     <= S_FILL;
                    end
                end
                S_FILL: begin
                    // Issue and receive advance independently; returns may overlap requests.
                    if (issuing) issue_cnt <= issue_cnt + CW'(1);
                    if (recv)    recv_cnt  <= recv_cnt + CW'(1);
                    if (last)    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a fixed-latency memory responder.
module tb_cache_fill_fsm;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        fsm_busy;
    logic        mem_read_req;
    logic [15:0] memory_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        write_data_array;
    logic        write_tag_array;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;

    cache_fill_fsm #(.ADDR_WIDTH(16), .BLOCK_WORDS(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .fsm_busy          (fsm_busy),
        .mem_read_req      (mem_read_req),
        .memory_address    (memory_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .write_data_array  (write_data_array),
        .write_tag_array   (write_tag_array),
        .fill_word         (fill_word),
        .fill_data         (fill_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int          cyc = 0;
    int          pend_q[$];
    int          req_cnt, wr_cnt, tag_cnt, busy_cnt, ret_idx, gap_ctr;
    int          gap_mode = 0;
    logic        idle_exp = 1'b0;
    logic        rst_drv  = 1'b1;
    logic [15:0] exp_base;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic cycle(input logic miss, input logic [15:0] maddr);
        logic v;
        logic ready;
        @(posedge clk);
        #1;
        cyc++;
        rst_n         = rst_drv;
        miss_detected = miss;
        miss_address  = maddr;
        ready = (pend_q.size() > 0) && (pend_q[0] <= cyc);
        v     = ready && (gap_mode == 0 || (gap_ctr % 3) == 0);
        if (ready) gap_ctr++;
        if (v) begin
            void'(pend_q.pop_front());
            memory_data_valid = 1'b1;
            memory_data       = 16'hA000 + 16'(ret_idx);
        end else begin
            memory_data_valid = 1'b0;
            memory_data       = 16'($urandom);
        end
        @(negedge clk);
        if (idle_exp) begin
            check("idle_busy", fsm_busy, 0);
            check("idle_req", mem_read_req, 0);
            check("idle_wda", write_data_array, 0);
            check("idle_wta", write_tag_array, 0);
            check("idle_word", fill_word, 0);
            check("idle_addr", memory_address, 0);
        end else begin
            check("wda", write_data_array, v);
            if (mem_read_req)
                check("req_addr", memory_address, 16'(exp_base + 16'(2 * req_cnt)));
            if (write_data_array) begin
                check("fill_word", fill_word, ret_idx % 8);
                check("fill_data", fill_data, 16'hA000 + 16'(ret_idx));
                check("tag_with_word", write_tag_array, (ret_idx == 7));
            end
        end
        if (mem_read_req) begin
            pend_q.push_back(cyc + LAT);
            req_cnt++;
        end
        if (write_data_array) wr_cnt++;
        if (write_tag_array)  tag_cnt++;
        if (fsm_busy)         busy_cnt++;
        if (v)                ret_idx++;
    endtask

    task automatic start_fill(input logic [15:0] addr, input logic [15:0] base);
        exp_base = base;
        req_cnt  = 0; wr_cnt = 0; tag_cnt = 0; busy_cnt = 0; ret_idx = 0; gap_ctr = 0;
        cycle(1'b1, addr);
        check("miss_busy", fsm_busy, 1);
        check("miss_noreq", mem_read_req, 0);
    endtask

    task automatic run_fill(input logic [15:0] addr, input logic [15:0] base,
                            input logic mid_miss, input logic [15:0] mid_addr, input int exp_busy);
        start_fill(addr, base);
        for (int n = 0; n < 100 && wr_cnt < 8; n++) cycle(mid_miss, mid_addr);
        check("req_cnt", req_cnt, 8);
        check("wr_cnt", wr_cnt, 8);
        check("tag_cnt", tag_cnt, 1);
        if (exp_busy > 0) check("busy_len", busy_cnt, exp_busy);
    endtask

    task automatic after_fill();
        cycle(1'b0, 16'h0000);
        check("post_busy", fsm_busy, 0);
        check("post_req", mem_read_req, 0);
        check("post_req_total", req_cnt, 8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with a stray valid on the memory bus.
        rst_n = 1'b0;
        miss_detected = 1'b0;
        miss_address = 16'h0000;
        memory_data_valid = 1'b1;
        memory_data = 16'hBEEF;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_busy", fsm_busy, 0);
            check("rst_req", mem_read_req, 0);
            check("rst_wda", write_data_array, 0);
            check("rst_wta", write_tag_array, 0);
            check("rst_addr", memory_address, 0);
            check("rst_word", fill_word, 0);
        end
        @(posedge clk);
        #1 memory_data_valid = 1'b0;

        // Back-to-back fill: 1 + LAT + 8 busy cycles.
        run_fill(16'h1236, 16'h1230, 1'b0, 16'h0000, 1 + LAT + 8);
        after_fill();

        // Valid pattern 1,0,0 repeating.
        gap_mode = 1;
        run_fill(16'h1236, 16'h1230, 1'b0, 16'h0000, 0);
        after_fill();
        gap_mode = 0;

        // Miss held during fill is ignored, then accepted right after the tag write.
        run_fill(16'h1236, 16'h1230, 1'b1, 16'h4000, 1 + LAT + 8);
        run_fill(16'h4000, 16'h4000, 1'b0, 16'h0000, 1 + LAT + 8);
        after_fill();

        // Top-of-address-space block stays inside 0xFFF0..0xFFFE.
        run_fill(16'hFFF8, 16'hFFF0, 1'b0, 16'h0000, 1 + LAT + 8);
        after_fill();

        // Reset after three received words; in-flight returns must be dropped.
        start_fill(16'h1236, 16'h1230);
        for (int n = 0; n < 40 && wr_cnt < 3; n++) cycle(1'b0, 16'h0000);
        check("abort_reach3", wr_cnt, 3);
        rst_drv = 1'b0;
        cycle(1'b0, 16'h0000);
        rst_drv = 1'b1;
        idle_exp = 1'b1;
        check("abort_inflight", (pend_q.size() > 0), 1);
        for (int n = 0; n < 30 && pend_q.size() > 0; n++) cycle(1'b0, 16'h0000);
        cycle(1'b0, 16'h0000);
        idle_exp = 1'b0;
        check("abort_drained", pend_q.size(), 0);
        check("abort_no_tag", tag_cnt, 0);
        pend_q.delete();

        run_fill(16'h2222, 16'h2220, 1'b0, 16'h0000, 1 + LAT + 8);
        after_fill();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
